// File: rtl/philo_ring.sv
// philo_ring: N philosophers in a ring passing a READING token and competing to eat.
// Optional starvation counters and mutex monitor are built when PHILO_STARVE_MON_EN is defined.
module philo_ring #(
  parameter int N        = 8,
  parameter int READER   = 0,
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 200
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [N-1:0]   coin,
  output logic [2*N-1:0] st,
  output logic [N-1:0]   starve,
  output logic           mutex_err
);

  typedef enum logic [1:0] {
    THINKING = 2'd0,
    READING  = 2'd1,
    EATING   = 2'd2,
    HUNGRY   = 2'd3
  } state_t;

  if (N < 3 || N > 32) begin : g_bad_n
    $error("philo_ring: N must be in 3..32");
  end
  if (READER < 0 || READER >= N) begin : g_bad_reader
    $error("philo_ring: READER must be in 0..N-1");
  end
  if (MAX_WAIT < 1 || longint'(MAX_WAIT) > ((longint'(1) << WAIT_W) - 1)) begin : g_bad_wait
    $error("philo_ring: MAX_WAIT must be in 1..2^WAIT_W-1");
  end

  function automatic logic [2*N-1:0] resetPattern();
    logic [2*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      v[2*i+:2] = (i == READER) ? READING : THINKING;
    end
    return v;
  endfunction

  localparam logic [2*N-1:0] LP_RESET = resetPattern();

  // lft is the (i+1) neighbour, rgt the (i-1) neighbour; all sampled pre-edge.
  function automatic state_t nextState(input state_t cur, input state_t lft,
                                       input state_t rgt, input logic c);
    state_t n;
    n = cur;
    case (cur)
      READING:  if (lft == THINKING) n = THINKING;
      THINKING: n = !c ? HUNGRY : ((rgt == READING) ? READING : THINKING);
      EATING:   if (c) n = THINKING;
      HUNGRY:   if (lft != EATING && rgt != HUNGRY && rgt != EATING) n = EATING;
      default:  n = cur;
    endcase
    return n;
  endfunction

  logic [2*N-1:0] r_state;
  logic [2*N-1:0] w_next;

  for (genvar i = 0; i < N; i++) begin : g_ph
    localparam int LP_L = (i + 1) % N;
    localparam int LP_R = (i + N - 1) % N;
    assign w_next[2*i+:2] = nextState(state_t'(r_state[2*i+:2]),
                                      state_t'(r_state[2*LP_L+:2]),
                                      state_t'(r_state[2*LP_R+:2]),
                                      coin[i]);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= LP_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  assign st = r_state;

`ifdef PHILO_STARVE_MON_EN
  localparam logic [WAIT_W-1:0] LP_SAT = '1;
  localparam logic [WAIT_W-1:0] LP_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] r_wait [N];
  logic              r_mutex;
  logic [N-1:0]      w_hungry;
  logic [N-1:0]      w_adjEat;

  for (genvar i = 0; i < N; i++) begin : g_mon
    localparam int LP_L = (i + 1) % N;
    assign w_hungry[i] = (r_state[2*i+:2] == HUNGRY);
    assign w_adjEat[i] = (r_state[2*i+:2] == EATING) && (r_state[2*LP_L+:2] == EATING);
    assign starve[i]   = (r_wait[i] >= LP_MAX);
  end

  // Counters saturate rather than wrap so a long-starved philosopher stays flagged.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        r_wait[i] <= '0;
      end
      r_mutex <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!w_hungry[i]) begin
          r_wait[i] <= '0;
        end else if (r_wait[i] != LP_SAT) begin
          r_wait[i] <= r_wait[i] + WAIT_W'(1);
        end
      end
      if (|w_adjEat) begin
        r_mutex <= 1'b1;
      end
    end
  end

  assign mutex_err = r_mutex;
`else
  assign starve    = '0;
  assign mutex_err = 1'b0;
`endif

endmodule

// File: tb/tb_philo_ring.sv
// tb_philo_ring: scoreboard bench for philo_ring with an integer-array reference model.
// Expected starve/mutex_err follow PHILO_STARVE_MON_EN the same way the design build does.
module tb_philo_ring;

  localparam int N        = 8;
  localparam int READER   = 0;
  localparam int WAIT_W   = 3;
  localparam int MAX_WAIT = 4;
  localparam int SAT      = (1 << WAIT_W) - 1;

  localparam int TH = 0;
  localparam int RD = 1;
  localparam int EA = 2;
  localparam int HU = 3;

  typedef struct {
    logic [2*N-1:0] st;
    logic [N-1:0]   starve;
    logic           mutex;
  } exp_t;

  logic           clock;
  logic           reset_n;
  logic [N-1:0]   coin;
  logic [2*N-1:0] st;
  logic [N-1:0]   starve;
  logic           mutex_err;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cycleNo    = 0;

  int   mSt[N];
  int   mCnt[N];
  bit   mMutex;

  philo_ring #(
    .N(N), .READER(READER), .WAIT_W(WAIT_W), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .coin(coin),
    .st(st),
    .starve(starve),
    .mutex_err(mutex_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference: one ring step computed from the philosophers' rules on plain ints.
  task automatic modelStep(input logic [N-1:0] c, input bit rst);
    int nx[N];
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mSt[i]  = (i == READER) ? RD : TH;
        mCnt[i] = 0;
      end
      mMutex = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        int l;
        int r;
        l = (i + 1) % N;
        r = (i + N - 1) % N;
        nx[i] = mSt[i];
        if (mSt[i] == RD && mSt[l] == TH) nx[i] = TH;
        if (mSt[i] == TH) nx[i] = (c[i] == 1'b0) ? HU : ((mSt[r] == RD) ? RD : TH);
        if (mSt[i] == EA && c[i]) nx[i] = TH;
        if (mSt[i] == HU && mSt[l] != EA && mSt[r] != HU && mSt[r] != EA) nx[i] = EA;
        if (mSt[i] == EA && mSt[l] == EA) mMutex = 1'b1;
        mCnt[i] = (mSt[i] == HU) ? ((mCnt[i] + 1 > SAT) ? SAT : mCnt[i] + 1) : 0;
      end
      for (int i = 0; i < N; i++) mSt[i] = nx[i];
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] c, input bit rst);
    exp_t e;
    @(negedge clock);
    coin    = c;
    reset_n = !rst;
    modelStep(c, rst);
    for (int i = 0; i < N; i++) begin
      e.st[2*i+:2] = 2'(mSt[i]);
`ifdef PHILO_STARVE_MON_EN
      e.starve[i] = (mCnt[i] >= MAX_WAIT);
`else
      e.starve[i] = 1'b0;
`endif
    end
`ifdef PHILO_STARVE_MON_EN
    e.mutex = mMutex;
`else
    e.mutex = 1'b0;
`endif
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycleNo, act, req);
    end
  endtask

  // Monitor: every edge that has an outstanding expectation is checked #1 after it.
  initial begin
    forever begin
      @(posedge clock);
      cycleNo++;
      #1;
      if (expQ.size() > 0) begin
        exp_t e;
        int   readers;
        e = expQ.pop_front();
        checkOutput("st", 64'(st), 64'(e.st));
        checkOutput("starve", 64'(starve), 64'(e.starve));
        checkOutput("mutex_err", 64'(mutex_err), 64'(e.mutex));
        readers = 0;
        for (int i = 0; i < N; i++) if (st[2*i+:2] == 2'd1) readers++;
        checkOutput("one_reader", 64'(readers <= 1), 64'(1));
      end
    end
  end

  initial begin
    logic [N-1:0] c;
    int density;
    coin    = '0;
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      mSt[i]  = TH;
      mCnt[i] = 0;
    end
    mMutex = 1'b0;

    $display("[TB] reset");
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);

    $display("[TB] token rotation with all coins high");
    for (int k = 0; k < 10; k++) applyStimulus('1, 1'b0);

    $display("[TB] all coins low, starvation and saturation");
    applyStimulus('0, 1'b1);
    for (int k = 0; k < 12; k++) applyStimulus('0, 1'b0);

    $display("[TB] eating philosopher released by its coin");
    applyStimulus(N'(2), 1'b0);
    for (int k = 0; k < 6; k++) applyStimulus('0, 1'b0);

    $display("[TB] mid-run reset with starve active");
    applyStimulus('0, 1'b1);
    for (int k = 0; k < 4; k++) applyStimulus('0, 1'b0);

    $display("[TB] randomized coins");
    density = 50;
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) density = $urandom_range(10, 90);
      for (int i = 0; i < N; i++) c[i] = ($urandom_range(0, 99) < density);
      applyStimulus(c, ($urandom_range(0, 499) == 0));
    end

    for (int k = 0; k < 20 && expQ.size() > 0; k++) @(posedge clock);
    #3;
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
